// File: rtl/motion_update_broadcaster.sv
// Motion-update broadcaster: sweeps every cell cache, computes pos + vel per particle and
// broadcasts the updated particle with its destination cell to all caches.
module motion_update_broadcaster #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 8,
  parameter int CELL_ID_WIDTH = 4,
  parameter int NUM_CELL_X    = 4,
  parameter int NUM_CELL_Y    = 4,
  parameter int NUM_CELL_Z    = 4,
  parameter int CELL_BITS     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic [3*CELL_ID_WIDTH-1:0] out_rd_cell,
  output logic [ADDR_WIDTH-1:0]      out_rd_address,
  output logic                       out_rden,
  input  logic [3*DATA_WIDTH-1:0]    in_pos_data,
  input  logic [3*DATA_WIDTH-1:0]    in_vel_data,
  output logic                       motion_update_enable,
  output logic                       out_data_valid,
  output logic [3*CELL_ID_WIDTH-1:0] out_dst_cell,
  output logic [3*DATA_WIDTH-1:0]    out_pos_data,
  output logic [3*DATA_WIDTH-1:0]    out_vel_data,
  output logic                       done
);

  localparam logic [CELL_ID_WIDTH-1:0] CELL_ONE = CELL_ID_WIDTH'(1);
  localparam logic [CELL_ID_WIDTH-1:0] LAST_X   = CELL_ID_WIDTH'(NUM_CELL_X);
  localparam logic [CELL_ID_WIDTH-1:0] LAST_Y   = CELL_ID_WIDTH'(NUM_CELL_Y);
  localparam logic [CELL_ID_WIDTH-1:0] LAST_Z   = CELL_ID_WIDTH'(NUM_CELL_Z);

  typedef enum logic [2:0] {
    IDLE, RD_COUNT, WAIT_COUNT, RD_PART, DRAIN, NEXT_CELL, FLUSH
  } state_t;

  state_t                   state_reg, state_next;
  logic [CELL_ID_WIDTH-1:0] cx_reg, cy_reg, cz_reg, cx_next, cy_next, cz_next;
  logic [ADDR_WIDTH-1:0]    addr_reg, addr_next, count_reg, count_next;
  logic [1:0]               wait_reg, wait_next;
  logic                     enable_reg, enable_next, done_reg, done_next;
  logic                     last_cell;

  assign last_cell            = (cx_reg == LAST_X) && (cy_reg == LAST_Y) && (cz_reg == LAST_Z);
  assign out_rd_cell          = {cx_reg, cy_reg, cz_reg};
  assign out_rden             = (state_reg == RD_COUNT) || (state_reg == RD_PART);
  assign out_rd_address       = (state_reg == RD_PART) ? addr_reg : '0;
  assign motion_update_enable = enable_reg;
  assign done                 = done_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      cx_reg     <= CELL_ONE;
      cy_reg     <= CELL_ONE;
      cz_reg     <= CELL_ONE;
      addr_reg   <= '0;
      count_reg  <= '0;
      wait_reg   <= '0;
      enable_reg <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cx_reg     <= cx_next;
      cy_reg     <= cy_next;
      cz_reg     <= cz_next;
      addr_reg   <= addr_next;
      count_reg  <= count_next;
      wait_reg   <= wait_next;
      enable_reg <= enable_next;
      done_reg   <= done_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cx_next     = cx_reg;
    cy_next     = cy_reg;
    cz_next     = cz_reg;
    addr_next   = addr_reg;
    count_next  = count_reg;
    wait_next   = wait_reg;
    enable_next = enable_reg;
    done_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          enable_next = 1'b1;
          cx_next     = CELL_ONE;
          cy_next     = CELL_ONE;
          cz_next     = CELL_ONE;
          state_next  = RD_COUNT;
        end
      end
      RD_COUNT: begin
        wait_next  = '0;
        state_next = WAIT_COUNT;
      end
      WAIT_COUNT: begin
        // Count word arrives on the second wait cycle.
        if (wait_reg == 2'd1) begin
          wait_next  = '0;
          count_next = in_pos_data[ADDR_WIDTH-1:0];
          addr_next  = ADDR_WIDTH'(1);
          state_next = (in_pos_data[ADDR_WIDTH-1:0] == '0) ? NEXT_CELL : RD_PART;
        end else begin
          wait_next = wait_reg + 2'd1;
        end
      end
      RD_PART: begin
        if (addr_reg == count_reg) begin
          wait_next  = '0;
          state_next = DRAIN;
        end else begin
          addr_next = addr_reg + ADDR_WIDTH'(1);
        end
      end
      DRAIN: begin
        if (wait_reg == 2'd2) begin
          wait_next  = '0;
          state_next = NEXT_CELL;
        end else begin
          wait_next = wait_reg + 2'd1;
        end
      end
      NEXT_CELL: begin
        if (last_cell) begin
          enable_next = 1'b0;
          wait_next   = '0;
          state_next  = FLUSH;
        end else begin
          state_next = RD_COUNT;
          if (cz_reg != LAST_Z) begin
            cz_next = cz_reg + CELL_ONE;
          end else begin
            cz_next = CELL_ONE;
            if (cy_reg != LAST_Y) begin
              cy_next = cy_reg + CELL_ONE;
            end else begin
              cy_next = CELL_ONE;
              cx_next = cx_reg + CELL_ONE;
            end
          end
        end
      end
      FLUSH: begin
        // Gives the caches time to write their particle count and swap buffers.
        if (wait_reg == 2'd2) begin
          wait_next  = '0;
          done_next  = 1'b1;
          state_next = IDLE;
        end else begin
          wait_next = wait_reg + 2'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  logic                       v1_reg, v2_reg;
  logic [3*DATA_WIDTH-1:0]    pos_sum;
  logic [3*CELL_ID_WIDTH-1:0] dst_calc;

  // Wrap-around of the sum is the periodic boundary; the top bits pick the cell.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_axis
      logic [DATA_WIDTH-1:0] new_pos;
      assign new_pos = in_pos_data[gi*DATA_WIDTH +: DATA_WIDTH] + in_vel_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign pos_sum[gi*DATA_WIDTH +: DATA_WIDTH] = new_pos;
      assign dst_calc[(2-gi)*CELL_ID_WIDTH +: CELL_ID_WIDTH] =
        CELL_ID_WIDTH'(new_pos[DATA_WIDTH-1 -: CELL_BITS]) + CELL_ONE;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_reg         <= 1'b0;
      v2_reg         <= 1'b0;
      out_data_valid <= 1'b0;
      out_pos_data   <= '0;
      out_vel_data   <= '0;
      out_dst_cell   <= '0;
    end else begin
      v1_reg         <= (state_reg == RD_PART);
      v2_reg         <= v1_reg;
      out_data_valid <= v2_reg;
      out_pos_data   <= v2_reg ? pos_sum : '0;
      out_vel_data   <= v2_reg ? in_vel_data : '0;
      out_dst_cell   <= v2_reg ? dst_calc : '0;
    end
  end

endmodule

// File: tb/tb_motion_update_broadcaster.sv
// Bench for motion_update_broadcaster: behavioural cache read model plus a scoreboard of
// expected broadcast words, with latency, ordering, enable/done timing and reset checks.
module tb_motion_update_broadcaster;

  logic         clk, rst, start;
  logic [11:0]  out_rd_cell, out_dst_cell;
  logic [7:0]   out_rd_address;
  logic         out_rden, motion_update_enable, out_data_valid, done;
  logic [95:0]  in_pos_data, in_vel_data, out_pos_data, out_vel_data;

  motion_update_broadcaster dut (
    .clk(clk), .rst(rst), .start(start),
    .out_rd_cell(out_rd_cell), .out_rd_address(out_rd_address), .out_rden(out_rden),
    .in_pos_data(in_pos_data), .in_vel_data(in_vel_data),
    .motion_update_enable(motion_update_enable), .out_data_valid(out_data_valid),
    .out_dst_cell(out_dst_cell), .out_pos_data(out_pos_data), .out_vel_data(out_vel_data),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [95:0] pos;
    logic [95:0] vel;
    logic [11:0] dst;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  logic [7:0]  mem_cnt [64];
  logic [95:0] mem_pos [64][8];
  logic [95:0] mem_vel [64][8];
  logic [95:0] d1_pos, d1_vel, d2_pos, d2_vel;
  logic [95:0] last_pos;
  logic [11:0] last_dst;
  int n_checks = 0, n_fail = 0;
  int cyc = 0, n_words = 0, n_done = 0, exp_cell = 0;
  int fall_cyc = 0, last_part_cyc = 0;
  bit prev_en = 0, prev_had = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor, scoreboard and cache read model, all on the falling edge.
  always @(negedge clk) begin
    exp_t        e;
    int          cidx;
    logic [31:0] np;
    cyc = cyc + 1;
    if (!rst) begin
      sb_q.delete();
      d1_pos = '0; d1_vel = '0; d2_pos = '0; d2_vel = '0;
      in_pos_data = '0; in_vel_data = '0;
      prev_en = 0;
    end else begin
      if (out_data_valid) begin
        n_words++;
        last_pos = out_pos_data;
        last_dst = out_dst_cell;
        check_eq("en_during_valid", motion_update_enable, 1);
        check_eq("sb_nonempty", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check_eq("word_pos", out_pos_data, e.pos);
          check_eq("word_vel", out_vel_data, e.vel);
          check_eq("word_dst", out_dst_cell, e.dst);
          check_eq("word_latency", cyc - e.cyc, 3);
        end
      end else begin
        check_eq("idle_zero", |{out_pos_data, out_vel_data, out_dst_cell}, 0);
      end
      if (prev_en && !motion_update_enable) fall_cyc = cyc;
      if (done) begin
        n_done++;
        check_eq("done_after_fall", cyc - fall_cyc, 3);
        check_eq("done_en_low", motion_update_enable, 0);
      end
      prev_en = motion_update_enable;

      in_pos_data = d2_pos; in_vel_data = d2_vel;
      d2_pos = d1_pos;      d2_vel = d1_vel;
      d1_pos = '0;          d1_vel = '0;
      if (out_rden) begin
        cidx = (int'(out_rd_cell[11:8]) - 1) * 16 + (int'(out_rd_cell[7:4]) - 1) * 4
             + (int'(out_rd_cell[3:0]) - 1);
        if (out_rd_address == 0) begin
          check_eq("cell_order", cidx, exp_cell);
          if (prev_had) check_eq("drain_gap", cyc - last_part_cyc, 5);
          exp_cell++;
          if (cidx >= 0 && cidx < 64) begin
            prev_had = (mem_cnt[cidx] != 0);
            d1_pos = {88'd0, mem_cnt[cidx]};
          end
        end else if (cidx >= 0 && cidx < 64 && out_rd_address <= 8) begin
          d1_pos = mem_pos[cidx][out_rd_address - 1];
          d1_vel = mem_vel[cidx][out_rd_address - 1];
          e.pos = '0; e.dst = '0;
          e.vel = d1_vel;
          e.cyc = cyc;
          for (int a = 0; a < 3; a++) begin
            np = d1_pos[a*32 +: 32] + d1_vel[a*32 +: 32];
            e.pos[a*32 +: 32] = np;
            e.dst[(2-a)*4 +: 4] = {2'b00, np[31:30]} + 4'd1;
          end
          sb_q.push_back(e);
          last_part_cyc = cyc;
        end
      end
    end
  end

  task automatic clear_mem();
    for (int c = 0; c < 64; c++) begin
      mem_cnt[c] = 0;
      for (int p = 0; p < 8; p++) begin
        mem_pos[c][p] = '0;
        mem_vel[c][p] = '0;
      end
    end
  endtask

  task automatic fill_full();
    for (int c = 0; c < 64; c++) begin
      mem_cnt[c] = 3;
      for (int p = 0; p < 3; p++) begin
        mem_pos[c][p] = {$urandom, $urandom, $urandom};
        mem_vel[c][p] = {$urandom, $urandom, $urandom};
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); #1;
    exp_cell = 0; prev_had = 0;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_update(input int exp_words, input bit busy_start);
    int w0, d0, i;
    w0 = n_words; d0 = n_done; i = 0;
    pulse_start();
    if (busy_start) begin
      repeat (20) @(negedge clk);
      #1 start = 1'b1;
      @(negedge clk);
      #1 start = 1'b0;
    end
    while (n_done == d0 && i < 3000) begin
      @(negedge clk); #1;
      i++;
    end
    repeat (10) @(negedge clk);
    #1;
    check_eq("done_count", n_done - d0, 1);
    check_eq("word_count", n_words - w0, exp_words);
    check_eq("sb_empty", sb_q.size(), 0);
    check_eq("cells_visited", exp_cell, 64);
  endtask

  task automatic single(input logic [31:0] px, input logic [31:0] vx,
                        input logic [31:0] want_x, input logic [11:0] want_dst, input string tag);
    clear_mem();
    mem_cnt[0] = 1;
    mem_pos[0][0] = {64'd0, px};
    mem_vel[0][0] = {64'd0, vx};
    run_update(1, 0);
    check_eq({tag, "_pos_x"}, last_pos[31:0], want_x);
    check_eq({tag, "_dst"}, last_dst, want_dst);
  endtask

  initial begin
    int d0, i;
    rst = 1'b0; start = 1'b0;
    in_pos_data = '0; in_vel_data = '0;
    d1_pos = '0; d1_vel = '0; d2_pos = '0; d2_vel = '0;
    last_pos = '0; last_dst = '0;
    clear_mem();
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_rd_cell", out_rd_cell, 12'h111);
    check_eq("rst_rden", out_rden, 0);
    check_eq("rst_addr", out_rd_address, 0);
    check_eq("rst_enable", motion_update_enable, 0);
    check_eq("rst_valid", out_data_valid, 0);
    check_eq("rst_data", |{out_pos_data, out_vel_data, out_dst_cell}, 0);
    check_eq("rst_done", done, 0);
    rst = 1'b1;

    single(32'h1000_0000, 32'h0100_0000, 32'h1100_0000, 12'h111, "single");
    single(32'h3FFF_FFF0, 32'h0000_0020, 32'h4000_0010, 12'h211, "cross");
    single(32'hFFFF_FFF0, 32'h0000_0020, 32'h0000_0010, 12'h111, "wrap");
    single(32'h0000_0010, 32'hFFFF_FFE0, 32'hFFFF_FFF0, 12'h411, "negvel");

    fill_full();
    run_update(192, 1);
    run_update(192, 0);

    clear_mem();
    run_update(0, 0);

    // Asynchronous abort in the middle of the particle reads.
    fill_full();
    pulse_start();
    i = 0;
    while (!(out_rden && out_rd_address != 0) && i < 200) begin
      @(negedge clk); #1;
      i++;
    end
    check_eq("reached_rd_part", out_rden && (out_rd_address != 0), 1);
    d0 = n_done;
    rst = 1'b0;
    #1;
    check_eq("abort_rden", out_rden, 0);
    check_eq("abort_enable", motion_update_enable, 0);
    check_eq("abort_valid", out_data_valid, 0);
    check_eq("abort_data", |{out_pos_data, out_vel_data, out_dst_cell}, 0);
    check_eq("abort_rd_cell", out_rd_cell, 12'h111);
    check_eq("abort_done", done, 0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    check_eq("no_done_after_abort", n_done - d0, 0);
    single(32'h1000_0000, 32'h0100_0000, 32'h1100_0000, 12'h111, "post_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
